// File: rtl/phase_sequencer.sv
// phase_sequencer: five-phase (IF, ID, EX, MEM, WB) control sequencer for
// the multicycle core. Produces one-hot phase enables and handles decoder-driven
// MEM/WB skipping, memory-wait stalls, halting at instruction boundaries,
// a stall watchdog and busy-cycle / retired-instruction counters.
//
// Ports:
//   CLK, RST          clock; asynchronous active-high reset
//   Start             leave IDLE/HALTED and fetch (ignored after a timeout)
//   HaltReq           level; stop at the next instruction boundary
//   MemReady          memory handshake; low stalls IF and MEM
//   SkipMem, SkipWB   decoder hints, sampled in ID only
//   Step              (SINGLE_STEP_EN only) release from PAUSE into IF
//   Phases[4:0]       one-hot enables [0]IF [1]ID [2]EX [3]MEM [4]WB
//   InstrDone         final non-stalled cycle of each instruction
//   Stalled           IF or MEM waiting on memory
//   Busy, Halted      in a phase state / in HALTED
//   Timeout           sticky watchdog error, cleared only by RST
//   CycleCount        busy cycles, saturating
//   InstrCount        completed instructions, wrapping
//
// Build option: define SINGLE_STEP_EN to add the Step input and a PAUSE
// state entered after every instruction that is not halting.
//
// state  | meaning
// IDLE   | out of reset, waiting for Start
// IF     | fetch, waits on MemReady
// ID     | decode, captures skip hints
// EX     | execute
// MEM    | memory access, waits on MemReady
// WB     | write back
// HALTED | stopped by HaltReq or watchdog
// PAUSE  | single-step hold between instructions (SINGLE_STEP_EN)

module phase_sequencer #(
  parameter int CNT_W     = 16,
  parameter int MAX_STALL = 15
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start,
  input  logic             HaltReq,
  input  logic             MemReady,
  input  logic             SkipMem,
  input  logic             SkipWB,
`ifdef SINGLE_STEP_EN
  input  logic             Step,
`endif
  output logic [4:0]       Phases,
  output logic             InstrDone,
  output logic             Stalled,
  output logic             Busy,
  output logic             Halted,
  output logic             Timeout,
  output logic [CNT_W-1:0] CycleCount,
  output logic [CNT_W-1:0] InstrCount
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_IF,
    S_ID,
    S_EX,
    S_MEM,
    S_WB,
    S_HALTED
`ifdef SINGLE_STEP_EN
    , S_PAUSE
`endif
  } state_t;

  state_t           state_q, state_d;
  logic             skip_mem_q, skip_mem_d;
  logic             skip_wb_q, skip_wb_d;
  logic [7:0]       stall_cnt_q, stall_cnt_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
  logic             boundary;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      skip_mem_q  <= 1'b0;
      skip_wb_q   <= 1'b0;
      stall_cnt_q <= 8'd0;
      timeout_q   <= 1'b0;
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      skip_mem_q  <= skip_mem_d;
      skip_wb_q   <= skip_wb_d;
      stall_cnt_q <= stall_cnt_d;
      timeout_q   <= timeout_d;
      cycle_cnt_q <= cycle_cnt_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    skip_mem_d  = skip_mem_q;
    skip_wb_d   = skip_wb_q;
    stall_cnt_d = 8'd0;
    timeout_d   = timeout_q;
    Phases      = 5'b00000;
    Stalled     = 1'b0;
    InstrDone   = 1'b0;
    boundary    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (Start) state_d = S_IF;
      end
      S_IF: begin
        Phases = 5'b00001;
        if (!MemReady) Stalled = 1'b1;
        else           state_d = S_ID;
      end
      S_ID: begin
        Phases     = 5'b00010;
        skip_mem_d = SkipMem;
        skip_wb_d  = SkipWB;
        state_d    = S_EX;
      end
      S_EX: begin
        Phases = 5'b00100;
        if (skip_mem_q && skip_wb_q) boundary = 1'b1;
        else if (skip_mem_q)         state_d  = S_WB;
        else                         state_d  = S_MEM;
      end
      S_MEM: begin
        Phases = 5'b01000;
        if (!MemReady)      Stalled  = 1'b1;
        else if (skip_wb_q) boundary = 1'b1;
        else                state_d  = S_WB;
      end
      S_WB: begin
        Phases   = 5'b10000;
        boundary = 1'b1;
      end
      S_HALTED: begin
        // a watchdog halt is only recoverable through RST
        if (Start && !timeout_q) state_d = S_IF;
      end
`ifdef SINGLE_STEP_EN
      S_PAUSE: begin
        if (HaltReq)   state_d = S_HALTED;
        else if (Step) state_d = S_IF;
      end
`endif
      default: state_d = S_IDLE;
    endcase

    if (boundary) begin
      InstrDone = 1'b1;
      if (HaltReq) state_d = S_HALTED;
`ifdef SINGLE_STEP_EN
      else         state_d = S_PAUSE;
`else
      else         state_d = S_IF;
`endif
    end

    // the MAX_STALL-th consecutive stalled cycle trips the watchdog
    if (Stalled) begin
      if (stall_cnt_q == 8'(MAX_STALL - 1)) begin
        timeout_d = 1'b1;
        state_d   = S_HALTED;
      end else begin
        stall_cnt_d = stall_cnt_q + 8'd1;
      end
    end
  end

  assign Busy = (state_q == S_IF) || (state_q == S_ID) || (state_q == S_EX) ||
                (state_q == S_MEM) || (state_q == S_WB);

  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    if (Busy && (cycle_cnt_q != '1)) cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
    instr_cnt_d = instr_cnt_q;
    if (InstrDone) instr_cnt_d = instr_cnt_q + CNT_W'(1);
  end

  assign Halted     = (state_q == S_HALTED);
  assign Timeout    = timeout_q;
  assign CycleCount = cycle_cnt_q;
  assign InstrCount = instr_cnt_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Bench for phase_sequencer: directed stimulus, an instruction-level model
// (each instruction is a list of phases still to run) checked every cycle,
// plus literal expectations at key points.

module tb_phase_sequencer;

  localparam int CNT_W     = 16;
  localparam int MAX_STALL = 15;
  localparam int P_IF = 0, P_ID = 1, P_EX = 2, P_MEM = 3, P_WB = 4;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             Start = 1'b0, HaltReq = 1'b0, MemReady = 1'b0;
  logic             SkipMem = 1'b0, SkipWB = 1'b0;
`ifdef SINGLE_STEP_EN
  logic             Step = 1'b0;
`endif
  logic [4:0]       Phases;
  logic             InstrDone, Stalled, Busy, Halted, Timeout;
  logic [CNT_W-1:0] CycleCount, InstrCount;

  int n_tests = 0;
  int n_fail  = 0;

  phase_sequencer #(.CNT_W(CNT_W), .MAX_STALL(MAX_STALL)) dut (
    .CLK(CLK), .RST(RST), .Start(Start), .HaltReq(HaltReq),
    .MemReady(MemReady), .SkipMem(SkipMem), .SkipWB(SkipWB),
`ifdef SINGLE_STEP_EN
    .Step(Step),
`endif
    .Phases(Phases), .InstrDone(InstrDone), .Stalled(Stalled), .Busy(Busy),
    .Halted(Halted), .Timeout(Timeout), .CycleCount(CycleCount),
    .InstrCount(InstrCount)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- instruction-level model ----------------
  int          rem[$];
  bit          m_run, m_halt, m_to;
  int          m_stall;
  int unsigned m_cyc, m_ins;

  initial begin
    forever begin
      @(posedge CLK or posedge RST);
      if (RST) begin
        rem = {}; m_run = 0; m_halt = 0; m_to = 0; m_stall = 0; m_cyc = 0; m_ins = 0;
      end else if (m_run) begin
        if (m_cyc < 65535) m_cyc++;
        if ((rem[0] == P_IF || rem[0] == P_MEM) && !MemReady) begin
          m_stall++;
          if (m_stall == MAX_STALL) begin
            m_to = 1; m_halt = 1; m_run = 0; m_stall = 0; rem = {};
          end
        end else begin
          m_stall = 0;
          if (rem[0] == P_ID) begin
            rem = {P_ID, P_EX};
            if (!SkipMem) rem.push_back(P_MEM);
            if (!SkipWB)  rem.push_back(P_WB);
          end
          void'(rem.pop_front());
          if (rem.size() == 0) begin
            m_ins = (m_ins + 1) % 65536;
            if (HaltReq) begin m_run = 0; m_halt = 1; end
            else rem = {P_IF, P_ID};
          end
        end
      end else if (Start && !m_to) begin
        m_run = 1; m_halt = 0; rem = {P_IF, P_ID};
      end
    end
  end

  // per-cycle comparison against the model, away from the rising edge
  always @(negedge CLK) begin
    logic [4:0] e_ph;
    logic       e_st, e_done;
    e_ph   = 5'b0;
    e_st   = 1'b0;
    e_done = 1'b0;
    if (m_run) begin
      e_ph   = 5'(1 << rem[0]);
      e_st   = (rem[0] == P_IF || rem[0] == P_MEM) && !MemReady;
      e_done = !e_st && rem.size() == 1 && rem[0] >= P_EX;
    end
    check("m_phases",   32'(Phases),     32'(e_ph));
    check("m_stalled",  32'(Stalled),    32'(e_st));
    check("m_done",     32'(InstrDone),  32'(e_done));
    check("m_busy",     32'(Busy),       32'(m_run));
    check("m_halted",   32'(Halted),     32'(m_halt));
    check("m_timeout",  32'(Timeout),    32'(m_to));
    check("m_cyclecnt", 32'(CycleCount), m_cyc);
    check("m_instrcnt", 32'(InstrCount), m_ins);
  end

  // ---------------- stimulus ----------------
  // applies inputs for the current cycle, then advances to 2ns after the edge
  task automatic drive(input logic st, hr, mr, sm, sw);
    Start = st; HaltReq = hr; MemReady = mr; SkipMem = sm; SkipWB = sw;
    @(posedge CLK);
    #2;
  endtask

  task automatic do_reset();
    Start = 0; HaltReq = 0; MemReady = 0; SkipMem = 0; SkipWB = 0;
    RST = 1'b1;
    #1;
    RST = 1'b0;
    #1;
  endtask

  initial begin
    #12;
    check("rst_phases", 32'(Phases), 32'h0);
    check("rst_busy",   32'(Busy),   32'h0);
    check("rst_halted", 32'(Halted), 32'h0);
    check("rst_cnts",   32'({CycleCount, InstrCount}), 32'h0);
    RST = 1'b0;
    @(posedge CLK); #2;

    // full five-phase instruction
    drive(1, 0, 1, 0, 0); check("t1_if",  32'(Phases), 32'h01);
    drive(0, 0, 1, 0, 0); check("t1_id",  32'(Phases), 32'h02);
    drive(0, 0, 1, 0, 0); check("t1_ex",  32'(Phases), 32'h04);
    drive(0, 0, 1, 0, 0); check("t1_mem", 32'(Phases), 32'h08);
    check("t1_nodone_mem", 32'(InstrDone), 32'h0);
    drive(0, 0, 1, 0, 0); check("t1_wb",  32'(Phases), 32'h10);
    check("t1_done_wb", 32'(InstrDone), 32'h1);
    drive(0, 0, 1, 0, 0); check("t1_if2", 32'(Phases), 32'h01);
    check("t1_icount", 32'(InstrCount), 32'd1);
    check("t1_ccount", 32'(CycleCount), 32'd5);

    // skip MEM (4 cycles), then skip MEM and WB (3 cycles)
    do_reset();
    drive(1, 0, 1, 0, 0);
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 1, 1, 0); check("t2_ex",  32'(Phases), 32'h04);
    drive(0, 0, 1, 0, 0); check("t2_wb",  32'(Phases), 32'h10);
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 1, 1, 1); check("t2_ex2", 32'(Phases), 32'h04);
    check("t2_done_ex", 32'(InstrDone), 32'h1);
    drive(0, 0, 1, 0, 0); check("t2_if",  32'(Phases), 32'h01);
    check("t2_icount", 32'(InstrCount), 32'd2);
    check("t2_ccount", 32'(CycleCount), 32'd7);

    // three-cycle memory wait in MEM
    do_reset();
    drive(1, 0, 1, 0, 0);
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 1, 0, 0); check("t3_mem", 32'(Phases), 32'h08);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0);
      check("t3_held",  32'(Phases),  32'h08);
      check("t3_stall", 32'(Stalled), 32'h1);
    end
    drive(0, 0, 1, 0, 0); check("t3_wb", 32'(Phases), 32'h10);
    check("t3_timeout", 32'(Timeout), 32'h0);
    drive(0, 0, 1, 0, 0);
    check("t3_ccount", 32'(CycleCount), 32'd8);

    // watchdog in IF
    do_reset();
    drive(1, 0, 1, 0, 0);
    for (int i = 0; i < MAX_STALL - 1; i++) drive(0, 0, 0, 0, 0);
    check("t4_pre_to",  32'(Timeout), 32'h0);
    check("t4_pre_if",  32'(Phases),  32'h01);
    drive(0, 0, 0, 0, 0);
    check("t4_timeout", 32'(Timeout), 32'h1);
    check("t4_halted",  32'(Halted),  32'h1);
    check("t4_icount",  32'(InstrCount), 32'd0);
    drive(1, 0, 1, 0, 0);
    drive(0, 0, 1, 0, 0);
    check("t4_start_ign", 32'(Halted), 32'h1);
    check("t4_busy",      32'(Busy),   32'h0);

    // halt request raised in EX
    do_reset();
    drive(1, 0, 1, 0, 0);
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 1, 0, 0);
    drive(0, 1, 1, 0, 0); check("t5_mem", 32'(Phases), 32'h08);
    drive(0, 1, 1, 0, 0); check("t5_wb",  32'(Phases), 32'h10);
    drive(0, 1, 1, 0, 0);
    check("t5_halted", 32'(Halted), 32'h1);
    check("t5_busy",   32'(Busy),   32'h0);
    check("t5_icount", 32'(InstrCount), 32'd1);
    drive(1, 1, 1, 0, 0); check("t5_restart", 32'(Phases), 32'h01);

    // saturate CycleCount
    for (int i = 0; i < 65540; i++) drive(0, 0, 1, 0, 0);
    check("t6_sat", 32'(CycleCount), 32'h0000FFFF);
    for (int i = 0; i < 6 && !(m_run && rem[0] == P_EX); i++) drive(0, 0, 1, 0, 0);
    check("t6_in_ex", 32'(Phases), 32'h04);

    // asynchronous reset mid-EX, observed before the next edge
    #1 RST = 1'b1;
    #1;
    check("t7_phases", 32'(Phases), 32'h0);
    check("t7_cnts",   32'({CycleCount, InstrCount}), 32'h0);
    check("t7_busy",   32'(Busy), 32'h0);
    RST = 1'b0;
    @(posedge CLK); #2;
    check("t7_idle", 32'(Phases), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/phase_sequencer.md
Name: phase_sequencer

Overview:
Control sequencer for the multicycle processor's five-phase execution (IF, ID, EX, MEM, WB). Drives one-hot phase enables to the datapath and handles per-instruction phase skipping, memory-wait stalls and halt. Also provides a stall watchdog and performance counters. Sits between the instruction decoder/memory interface and all phase-gated datapath registers.

Parameters:
CNT_W, 16, width of CycleCount and InstrCount
MAX_STALL, 15, consecutive stall cycles allowed before watchdog timeout (1..255)

Ports:
CLK  input  1  clock; all state changes on rising edge
RST  input  1  asynchronous active-high reset
Start  input  1  leaves IDLE or HALTED and begins fetch
HaltReq  input  1  level; stop at next instruction boundary
MemReady  input  1  memory handshake; 0 during IF or MEM stalls that phase
SkipMem  input  1  from decoder, sampled in ID; instruction has no MEM phase
SkipWB  input  1  from decoder, sampled in ID; instruction has no WB phase
Phases  output  5  one-hot phase enables: [0]IF [1]ID [2]EX [3]MEM [4]WB
InstrDone  output  1  high during the final, non-stalled phase cycle of each instruction
Stalled  output  1  high while in IF or MEM with MemReady=0
Busy  output  1  high in any phase state
Halted  output  1  high in HALTED
Timeout  output  1  sticky watchdog error; cleared only by RST
CycleCount  output  CNT_W  busy cycles, saturating
InstrCount  output  CNT_W  completed instructions, wrapping

Behaviour:
- States: IDLE, IF, ID, EX, MEM, WB, HALTED. Phases is exactly one-hot in IF..WB and all-zero in IDLE and HALTED.
- RST asserted (any time, including mid-instruction): state=IDLE. Phases=0, InstrDone=0, Stalled=0, Busy=0, Halted=0, Timeout=0. Both counters=0, stall counter=0, latched skip bits=0.
- IDLE: Start=1 -> IF; otherwise stay.
- IF: MemReady=0 -> stay, Stalled=1; MemReady=1 -> ID.
- ID: latch SkipMem and SkipWB into internal registers -> EX. Inputs are ignored outside ID.
- EX: both skip bits set -> boundary. SkipMem only -> WB. Otherwise -> MEM.
- MEM: MemReady=0 -> stay, Stalled=1. MemReady=1 and SkipWB latched -> boundary; else -> WB.
- WB: always boundary.
- Boundary: InstrDone=1 for that cycle and InstrCount+1 (wraps). Next state is HALTED if HaltReq=1 that cycle, else IF.
- HALTED: Start=1 -> IF; HaltReq is ignored while halted.
- Watchdog: stall counter increments each Stalled cycle and clears on any non-stalled cycle. When the counter reaches MAX_STALL while still stalled: set Timeout and go to HALTED next cycle, with no InstrDone.
- Start while HALTED with Timeout=1 is ignored; only RST recovers.
- CycleCount increments every cycle Busy=1 and holds at all-ones.
- Minimum instruction length is 3 cycles; maximum without stalls is 5.

Optional Feature:
SINGLE_STEP_EN
- Defined: adds input Step (1 bit) and state PAUSE. A boundary with HaltReq=0 goes to PAUSE instead of IF. In PAUSE, Phases=0 and Busy=0. Step=1 -> IF. HaltReq=1 in PAUSE -> HALTED, with HaltReq taking priority over Step.
- Undefined: no Step port, no PAUSE state; boundary goes directly to IF.

Test Plan:
- RST pulse mid-EX, asynchronous between edges -> Phases=00000, counters=0 immediately, before the next CLK edge.
- Start, MemReady=1, SkipMem=0/SkipWB=0 -> Phases 00001,00010,00100,01000,10000,00001. InstrDone only in the WB cycle. InstrCount=1 after 5 cycles.
- SkipMem=1/SkipWB=0 then SkipMem=1/SkipWB=1 -> 4-cycle instruction (IF,ID,EX,WB) then 3-cycle instruction ending in EX. InstrCount=2, CycleCount=7.
- MemReady=0 for 3 cycles in MEM -> MEM held 3 extra cycles with Stalled=1, then WB. Timeout=0.
- MemReady=0 held in IF with MAX_STALL=15 -> Timeout=1 after 15 stalled cycles, then HALTED. A following Start is ignored.
- HaltReq=1 raised during EX -> instruction completes through WB, then HALTED, Busy=0. Start -> IF. CycleCount saturates at 16'hFFFF when forced near max.
